// File: rtl/multibyte_add_sequencer_if.sv
// Requester-side handshake bundle for multibyte_add_sequencer.
// The optional sub request line exists only when ADD_SUB_EN is defined.
interface multibyte_add_sequencer_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
`ifdef ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;

`ifdef ADD_SUB_EN
  modport master (
    output start, a_in, b_in, sub,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, a_in, b_in, sub,
    output busy, done, result, carry_out
  );
`else
  modport master (
    output start, a_in, b_in,
    input  busy, done, result, carry_out
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, result, carry_out
  );
`endif
endinterface

// File: rtl/multibyte_add_sequencer.sv
// Drives one external 8-bit adder to add two NBYTES-wide operands a byte at a time, LSB first.
// Optional feature: define ADD_SUB_EN to add a sub request that computes A-B mod 2^W.
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  multibyte_add_sequencer_if.slave    bus,
  output logic [7:0]                  add_a,
  output logic [7:0]                  add_b,
  input  logic [7:0]                  add_sum,
  input  logic                        add_c8
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    CIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             cy_q, cy_d;
  logic             c1_q, c1_d;
  logic [7:0]       part_q, part_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       add_a_q, add_a_d;
  logic [7:0]       add_b_q, add_b_d;
  logic             sub_req;

`ifdef ADD_SUB_EN
  assign sub_req = bus.sub;
`else
  assign sub_req = 1'b0;
`endif

  function automatic logic [7:0] byte_of(input logic [W-1:0] v, input logic [IDX_W-1:0] i);
    byte_of = 8'(v >> (int'(i) * 8));
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cy_d        = cy_q;
    c1_d        = c1_q;
    part_d      = part_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + 1: the +1 rides in as the initial carry.
          a_d         = bus.a_in;
          b_d         = sub_req ? ~bus.b_in : bus.b_in;
          idx_d       = '0;
          cy_d        = sub_req;
          carry_out_d = 1'b0;
          state_d     = ADD;
        end
      end
      ADD: begin
        part_d  = add_sum;
        c1_d    = add_c8;
        state_d = CIN;
      end
      CIN: begin
        for (int k = 0; k < NBYTES; k++) begin
          if (idx_q == IDX_W'(k)) result_d[k*8 +: 8] = add_sum;
        end
        // A+B carry and partial+cin carry are mutually exclusive, so OR is exact.
        cy_d = c1_q | add_c8;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ADD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == DONE) carry_out_d = cy_d;

    // Adder operands are registered, so they are chosen from the state being entered.
    add_a_d = 8'd0;
    add_b_d = 8'd0;
    case (state_d)
      ADD: begin
        add_a_d = byte_of(a_d, idx_d);
        add_b_d = byte_of(b_d, idx_d);
      end
      CIN: begin
        add_a_d = part_d;
        add_b_d = {7'b0, cy_d};
      end
      default: ;
    endcase

    busy_d = (state_d == ADD) || (state_d == CIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      add_a_q     <= 8'd0;
      add_b_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cy_q        <= cy_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
    end
  end

  // Operand and scratch registers are only read after being loaded in the same run.
  always_ff @(posedge clk) begin
    a_q    <= a_d;
    b_q    <= b_d;
    part_q <= part_d;
    c1_q   <= c1_d;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign add_a         = add_a_q;
  assign add_b         = add_b_q;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed bench for multibyte_add_sequencer (NBYTES=4) with a combinational 8-bit adder model.
module tb_multibyte_add_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_c8;
  logic [8:0] add_full;

  int compared   = 0;
  int mismatched = 0;

  multibyte_add_sequencer_if #(.NBYTES(NB)) bus ();

  multibyte_add_sequencer #(.NBYTES(NB)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_sum (add_sum),
    .add_c8  (add_c8)
  );

  assign add_full = 9'(add_a) + 9'(add_b);
  assign add_sum  = add_full[7:0];
  assign add_c8   = add_full[8];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one operation; optionally pulses start during cycles 2 and 4 of the run.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] exp_r, input logic exp_c,
                        input logic pulse_start);
    int n;
    logic seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
`ifdef ADD_SUB_EN
    bus.sub   = sub;
`endif
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a_in  = 32'hAAAA_AAAA;
    bus.b_in  = 32'h5555_5555;
    seen = 1'b0;
    n    = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      n = c;
      if (c == 1) begin
        check({tag, "_busy1"}, W'(bus.busy), W'(1'b1));
        check({tag, "_adda1"}, W'(add_a), W'(a[7:0]));
      end
      if (bus.done) seen = 1'b1;
      bus.start = pulse_start && (c == 1 || c == 3);
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, W'(seen), W'(1'b1));
    check({tag, "_latency"}, W'(n), W'(2 * NB + 1));
    check({tag, "_result"}, bus.result, exp_r);
    check({tag, "_carry"}, W'(bus.carry_out), W'(exp_c));
    check({tag, "_busy_at_done"}, W'(bus.busy), W'(1'b0));
    if (pulse_start) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
        check({tag, "_no_second_done"}, W'(bus.done), W'(1'b0));
        check({tag, "_idle_busy"}, W'(bus.busy), W'(1'b0));
      end
    end else begin
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, W'(bus.done), W'(1'b0));
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
`ifdef ADD_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",   W'(bus.busy),      '0);
    check("rst_done",   W'(bus.done),      '0);
    check("rst_result", bus.result,        '0);
    check("rst_carry",  W'(bus.carry_out), '0);
    check("rst_adda",   W'(add_a),         '0);
    check("rst_addb",   W'(add_b),         '0);
    @(negedge clk);
    reset = 1'b0;

    run_op("t1", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    run_op("t2", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
    run_op("t3", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("t4", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    run_op("t5_ign", 32'h0000_FF01, 32'h0000_01FF, 1'b0, 32'h0001_0100, 1'b0, 1'b1);

    // Reset in the middle of a run.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a_in  = 32'h1111_1111;
    bus.b_in  = 32'h2222_2222;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rst_busy",   W'(bus.busy), '0);
    check("t5_rst_result", bus.result,   '0);
    check("t5_rst_done",   W'(bus.done), '0);
    check("t5_rst_adda",   W'(add_a),    '0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      check("t5_rst_no_done", W'(bus.done), '0);
    end
    run_op("t5_fresh", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

`ifdef ADD_SUB_EN
    run_op("t6_sub_pos", 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
    run_op("t6_sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
